// File: rtl/adc_capture_ctrl.sv
// Paced ADC acquisition sequencer: converts, synchronizes adcDone, and writes one
// byte per sample into the shared BRAM above the reserved control bytes.
module adc_capture_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] sampleCount,
  input  logic [15:0]       divider,
  input  logic [DATA_W-1:0] adcData,
  input  logic              adcDone,
  output logic              adcConv,
  output logic [ADDR_W-1:0] busBramAddr,
  output logic [DATA_W-1:0] busBramOut,
  output logic              ctrlWeBram,
  output logic              stmBusy,
  output logic              capDone,
  output logic              errTimeout,
  output logic              errOverrun
);

  localparam int                TO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [ADDR_W-1:0] CNT_MAX  = ADDR_W'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [15:0]       MIN_DIV  = 16'd5;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARM, CONV, WAIT, WRITE, DONE} state_t;

  state_t            state;
  logic              sync1, sync2, sync2_d, done_rise;
  logic [ADDR_W-1:0] remaining;
  logic [15:0]       period_m1, tmr;
  logic [TO_W-1:0]   tcnt;
  logic              clean;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync2_d     <= 1'b0;
      done_rise   <= 1'b0;
      remaining   <= '0;
      period_m1   <= '0;
      tmr         <= '0;
      tcnt        <= '0;
      clean       <= 1'b0;
      adcConv     <= 1'b0;
      busBramAddr <= BASE;
      busBramOut  <= '0;
      ctrlWeBram  <= 1'b0;
      stmBusy     <= 1'b0;
      capDone     <= 1'b0;
      errTimeout  <= 1'b0;
      errOverrun  <= 1'b0;
    end else begin
      sync1     <= adcDone;
      sync2     <= sync1;
      sync2_d   <= sync2;
      done_rise <= sync2 & ~sync2_d;
      capDone   <= 1'b0;

      // Period timer free-runs from each CONV; a zero value is one pacing tick.
      if (tmr == '0) tmr <= period_m1;
      else           tmr <= tmr - 16'd1;

      case (state)
        IDLE: begin
          if (stmBusy) begin
            stmBusy <= 1'b0;
          end else if (start) begin
            remaining   <= (sampleCount > CNT_MAX) ? CNT_MAX : sampleCount;
            period_m1   <= (divider < MIN_DIV) ? MIN_DIV : divider;
            errTimeout  <= 1'b0;
            errOverrun  <= 1'b0;
            busBramAddr <= BASE;
            stmBusy     <= 1'b1;
            clean       <= 1'b1;
            tmr         <= '0;
            state       <= ARM;
          end
        end
        ARM: begin
          if (abort) begin
            clean <= 1'b0;
            state <= DONE;
          end else if (remaining == '0) begin
            state <= DONE;
          end else if (tmr == '0) begin
            tmr     <= period_m1;
            adcConv <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          adcConv <= 1'b0;
          tcnt    <= '0;
          if (abort) begin
            clean <= 1'b0;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          tcnt <= tcnt + TO_W'(1);
          if (tmr == '0) errOverrun <= 1'b1;
          if (abort) begin
            clean <= 1'b0;
            state <= DONE;
          end else if (done_rise) begin
            busBramOut <= adcData;
            ctrlWeBram <= 1'b1;
            state      <= WRITE;
          end else if (tcnt == TO_LAST) begin
            errTimeout <= 1'b1;
            clean      <= 1'b0;
            state      <= DONE;
          end
        end
        WRITE: begin
          ctrlWeBram <= 1'b0;
          remaining  <= remaining - ADDR_W'(1);
          // Saturate so the pointer can never wrap into the reserved bytes.
          if (busBramAddr != TOP_ADDR) busBramAddr <= busBramAddr + ADDR_W'(1);
          if (tmr == '0) errOverrun <= 1'b1;
          if (abort) begin
            clean <= 1'b0;
            state <= DONE;
          end else begin
            state <= ARM;
          end
        end
        DONE: begin
          capDone <= clean;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
